// File: rtl/maxpool_stream_pkg.sv
// Shared types and constants for the streaming max/average pooling block.
package maxpool_stream_pkg;

    localparam int DATA_WIDTH_DEFAULT = 48;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } pool_state_e;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/maxpool_stream_if.sv
// Sample/result stream bundle between the convolution output and the pooler.
interface maxpool_stream_if #(
    parameter int NUM_CH     = 1,
    parameter int DATA_WIDTH = 48
);
    logic                         i_clean;
    logic                         i_valid;
    logic                         i_mode;
    logic [NUM_CH*DATA_WIDTH-1:0] i_data;
    logic                         o_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] o_data;
    logic                         o_busy;

    modport master (
        output i_clean, i_valid, i_mode, i_data,
        input  o_valid, o_data, o_busy
    );

    modport slave (
        input  i_clean, i_valid, i_mode, i_data,
        output o_valid, o_data, o_busy
    );
endinterface

// File: rtl/maxpool_stream_pool_lane.sv
// One pooling lane: widened accumulator with max/add update; result reflects
// the accumulator including the sample presented this cycle.
module pool_lane
    import maxpool_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int POOL_LOG2  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         update,
    input  pool_mode_e                   mode_q,
    input  logic signed [DATA_WIDTH-1:0] data,
    output logic signed [DATA_WIDTH-1:0] result
);
    localparam int AW = DATA_WIDTH + POOL_LOG2;

    logic signed [AW-1:0] acc_reg;
    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] data_ext;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] shifted;

    always_comb begin
        data_ext = {{POOL_LOG2{data[DATA_WIDTH-1]}}, data};
        sum      = acc_reg + data_ext;
        acc_next = acc_reg;
        if (load) begin
            acc_next = data_ext;
        end else if (update) begin
            if (mode_q == MODE_AVG) begin
                acc_next = sum;
            end else begin
                // Ties keep the stored value.
                acc_next = (data_ext > acc_reg) ? data_ext : acc_reg;
            end
        end
        shifted = acc_next >>> POOL_LOG2;
        result  = (mode_q == MODE_AVG) ? shifted[DATA_WIDTH-1:0] : acc_next[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (load || update) begin
            acc_reg <= acc_next;
        end
    end

endmodule

// File: rtl/maxpool_stream.sv
// Multi-lane streaming pooler: shared window counter/mode, one pool_lane per
// channel, registered results with a single-cycle valid pulse.
module maxpool_stream
    import maxpool_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int NUM_CH     = 1,
    parameter int POOL_SIZE  = 4,
    parameter int POOL_LOG2  = $clog2(POOL_SIZE)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    maxpool_stream_if.slave  bus
);
    localparam logic [POOL_LOG2-1:0] CNT_LAST = POOL_LOG2'(POOL_SIZE - 1);
    localparam logic [POOL_LOG2-1:0] CNT_ONE  = POOL_LOG2'(1);

    generate
        if (POOL_SIZE < 2 || !is_pow2(POOL_SIZE)) begin : g_bad_pool_size
            $error("maxpool_stream: POOL_SIZE must be a power of 2 and at least 2");
        end
    endgenerate

    pool_state_e            state_reg, state_next;
    logic [POOL_LOG2-1:0]   cnt_reg, cnt_next;
    pool_mode_e             mode_reg, mode_next;
    logic                   o_valid_reg;
    logic                   start, upd, fire, lane_rst;
    logic signed [DATA_WIDTH-1:0] lane_result [NUM_CH];
    logic        [DATA_WIDTH-1:0] o_data_reg  [NUM_CH];

    always_comb begin
        start      = 1'b0;
        upd        = 1'b0;
        fire       = 1'b0;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        if (bus.i_valid) begin
            // A clean alongside a sample discards the old window and opens a new one.
            if (bus.i_clean || state_reg == ST_IDLE) begin
                start     = 1'b1;
                mode_next = pool_mode_e'(bus.i_mode);
                cnt_next  = CNT_ONE;
            end else begin
                upd = 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    fire     = 1'b1;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
        end else if (bus.i_clean) begin
            cnt_next = '0;
        end
        state_next = (cnt_next == '0) ? ST_IDLE : ST_ACC;
        lane_rst   = i_rst || (bus.i_clean && !bus.i_valid);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            mode_reg    <= MODE_MAX;
            o_valid_reg <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                o_data_reg[k] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            mode_reg    <= mode_next;
            o_valid_reg <= fire;
            if (fire) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    o_data_reg[k] <= lane_result[k];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
            pool_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .POOL_LOG2  (POOL_LOG2)
            ) u_lane (
                .clk    (i_clk),
                .rst    (lane_rst),
                .load   (start),
                .update (upd),
                .mode_q (mode_reg),
                .data   (bus.i_data[gi*DATA_WIDTH +: DATA_WIDTH]),
                .result (lane_result[gi])
            );
            assign bus.o_data[gi*DATA_WIDTH +: DATA_WIDTH] = o_data_reg[gi];
        end
    endgenerate

    assign bus.o_valid = o_valid_reg;
    assign bus.o_busy  = (state_reg == ST_ACC);

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: directed windows plus random traffic, checked
// every cycle against a window-list model of the pooling rules.
module tb_maxpool_stream;
    localparam int NCH = 2;
    localparam int DW  = 48;
    localparam int PS  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maxpool_stream_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus();

    maxpool_stream #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .POOL_SIZE  (PS)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 0;

    // Model state: the samples of the open window, kept as plain integers.
    int                 m_cnt;
    bit                 m_mode;
    longint             m_win [NCH][$];
    logic [NCH*DW-1:0]  m_data;
    bit                 m_valid;
    bit                 m_busy;

    function automatic longint get_lane(input logic [NCH*DW-1:0] d, input int k);
        logic signed [DW-1:0] t;
        t = d[k*DW +: DW];
        return longint'(t);
    endfunction

    function automatic longint pool(input longint s[$], input bit mode);
        longint r, sum;
        if (!mode) begin
            r = s[0];
            foreach (s[i]) if (s[i] > r) r = s[i];
        end else begin
            sum = 0;
            foreach (s[i]) sum += s[i];
            r = sum / PS;
            if (sum < 0 && (sum % PS) != 0) r = r - 1;
        end
        return r;
    endfunction

    initial begin
        m_cnt = 0; m_mode = 0; m_data = '0; m_valid = 0; m_busy = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cnt = 0; m_mode = 0; m_data = '0; m_valid = 0;
                for (int k = 0; k < NCH; k++) m_win[k].delete();
            end else begin
                m_valid = 0;
                if (bus.i_valid) begin
                    if (bus.i_clean || m_cnt == 0) begin
                        for (int k = 0; k < NCH; k++) m_win[k].delete();
                        m_mode = bus.i_mode;
                        m_cnt  = 0;
                    end
                    for (int k = 0; k < NCH; k++) m_win[k].push_back(get_lane(bus.i_data, k));
                    m_cnt++;
                    if (m_cnt == PS) begin
                        for (int k = 0; k < NCH; k++) begin
                            longint r;
                            r = pool(m_win[k], m_mode);
                            m_data[k*DW +: DW] = r[DW-1:0];
                            m_win[k].delete();
                        end
                        m_valid = 1;
                        m_cnt   = 0;
                    end
                end else if (bus.i_clean) begin
                    m_cnt = 0;
                    for (int k = 0; k < NCH; k++) m_win[k].delete();
                end
            end
            m_busy = (m_cnt != 0);
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                n_tests++;
                if (bus.o_valid !== m_valid) begin
                    n_fail++;
                    $display("[TB] FAIL o_valid: got %b want %b at %0t", bus.o_valid, m_valid, $time);
                end
                n_tests++;
                if (bus.o_busy !== m_busy) begin
                    n_fail++;
                    $display("[TB] FAIL o_busy: got %b want %b at %0t", bus.o_busy, m_busy, $time);
                end
                n_tests++;
                if (bus.o_data !== m_data) begin
                    n_fail++;
                    $display("[TB] FAIL o_data: got %h want %h at %0t", bus.o_data, m_data, $time);
                end
                if (bus.o_valid === 1'b1)
                    $display("[TB] out lane0=%0d lane1=%0d", get_lane(bus.o_data, 0), get_lane(bus.o_data, 1));
            end
        end
    end

    task automatic step(input bit v, input bit c, input bit m, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bus.i_valid = v;
        bus.i_clean = c;
        bus.i_mode  = m;
        bus.i_data  = {d1, d0};
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
    endtask

    // Pins both the model and the DUT to a hand-computed lane value.
    task automatic check_lit(input string name, input int k, input longint want);
        n_tests++;
        if (get_lane(m_data, k) != want) begin
            n_fail++;
            $display("[TB] FAIL model_%s: got %0d want %0d", name, get_lane(m_data, k), want);
        end
        n_tests++;
        if (get_lane(bus.o_data, k) != want) begin
            n_fail++;
            $display("[TB] FAIL dut_%s: got %0d want %0d", name, get_lane(bus.o_data, k), want);
        end
    endtask

    function automatic logic [DW-1:0] rnd48();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 9))
            0:       return 48'h7FFF_FFFF_FFFF;
            1:       return 48'h8000_0000_0000;
            2:       return '1;
            3:       return DW'($urandom_range(0, 20));
            default: return r[DW-1:0];
        endcase
    endfunction

    initial begin
        int pulses;
        bus.i_valid = 0; bus.i_clean = 0; bus.i_mode = 0; bus.i_data = '0;
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        check_en = 1;
        idle(1);

        // Max, contiguous
        step(1, 0, 0, 5, -10);
        step(1, 0, 0, -3, -2);
        step(1, 0, 0, 12, -8);
        step(1, 0, 0, 7, -20);
        check_lit("max_l0", 0, 12);
        check_lit("max_l1", 1, -2);
        idle(2);

        // Average with floor rounding
        step(1, 0, 1, 1, -1);
        step(1, 0, 1, 2, -1);
        step(1, 0, 1, 3, -1);
        step(1, 0, 1, 4, -2);
        check_lit("avg_l0", 0, 2);
        check_lit("avg_l1", 1, -2);
        idle(1);

        // Average at the extremes of the range
        for (int i = 0; i < 4; i++) step(1, 0, 1, 48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000);
        check_lit("avg_big_l0", 0, 64'sd140737488355327);
        check_lit("avg_big_l1", 1, -64'sd140737488355328);
        idle(1);

        // Gaps with mode toggled after the first sample (window stays max)
        step(1, 0, 0, 3, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 1, 10, 2);
        step(0, 0, 1, 0, 0);
        step(1, 0, 1, -4, 3);
        step(1, 0, 1, 6, 4);
        check_lit("gap_l0", 0, 10);
        check_lit("gap_l1", 1, 4);
        idle(1);

        // Clean with a sample restarts the window
        step(1, 0, 0, 50, 50);
        step(1, 0, 0, 60, 60);
        step(1, 1, 0, 9, -7);
        step(1, 0, 0, 1, -9);
        step(1, 0, 0, 1, -9);
        step(1, 0, 0, 1, -9);
        check_lit("clean_l0", 0, 9);
        check_lit("clean_l1", 1, -7);
        // Clean without a sample drops a partial window
        step(1, 0, 1, 100, 100);
        step(0, 1, 0, 0, 0);
        idle(1);

        // Reset mid-window
        step(1, 0, 0, 40, 40);
        step(1, 0, 0, 41, 41);
        step(1, 0, 0, 42, 42);
        rst = 1;
        step(0, 0, 0, 0, 0);
        rst = 0;
        check_lit("rst_l0", 0, 0);
        check_lit("rst_l1", 1, 0);
        step(1, 0, 1, 8, -8);
        step(1, 0, 1, 8, -8);
        step(1, 0, 1, 8, -8);
        step(1, 0, 1, 9, -9);
        check_lit("post_rst_l0", 0, 8);
        check_lit("post_rst_l1", 1, -9);
        idle(1);

        // Back-to-back windows
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, DW'(i), DW'(-i));
            if (bus.o_valid === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 2) begin
            n_fail++;
            $display("[TB] FAIL b2b_pulses: got %0d want 2", pulses);
        end
        check_lit("b2b_l0", 0, 7);
        check_lit("b2b_l1", 1, -4);
        idle(3);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
                 $urandom_range(0, 1), rnd48(), rnd48());
        end
        rst = 0;
        idle(3);

        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
